// File: rtl/sdp_ram_ctrl.sv
// Simple dual-port inferred RAM with byte-enabled write port, 1/2-cycle read port,
// selectable read-during-write behaviour and a clear engine that sweeps INIT_VAL.
module sdp_ram_ctrl #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       RD_LAT   = 1,
  parameter int unsigned       RDW_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                clr_req,
  output logic                clr_busy,
  input  logic                wr_en,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_ready,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic                pwr_pend;
  logic                wr_fire_c;
  logic                rd_fire_c;
  logic [DATA_W-1:0]   wr_mask_c;
  logic [DATA_W-1:0]   mem_rd_c;
  logic [DATA_W-1:0]   rd_word_c;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Clear engine: power-on sweep pending after reset, or an explicit request from IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (pwr_pend || clr_req) state_nxt = CLEAR;
      end
      CLEAR: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == {ADDR_W{1'b1}}) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pwr_pend <= 1'b1;
      clr_busy <= 1'b0;
      wr_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pwr_pend <= 1'b0;
      clr_busy <= (state_nxt == CLEAR);
      wr_ready <= (state_nxt != CLEAR);
    end
  end

  assign wr_fire_c = wr_en && wr_ready;
  assign rd_fire_c = rd_en && !clr_busy;

  always_comb begin
    wr_mask_c = '0;
    for (int i = 0; i < BE_W; i++) begin
      wr_mask_c[8*i +: 8] = {8{wr_be[i]}};
    end
  end

  // Write-first forwarding merges the incoming bytes over the stored word
  assign mem_rd_c = mem[rd_addr];
  always_comb begin
    rd_word_c = mem_rd_c;
    if ((RDW_MODE == 1) && wr_fire_c && (wr_addr == rd_addr)) begin
      rd_word_c = (mem_rd_c & ~wr_mask_c) | (wr_data & wr_mask_c);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (clr_busy) begin
      mem[cnt] <= INIT_VAL;
    end else if (wr_fire_c) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;

    // Extra output register stage; data registers only load on valid so rd_data holds
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        s1_data  <= '0;
        s1_valid <= 1'b0;
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        s1_valid <= rd_fire_c;
        if (rd_fire_c) s1_data <= rd_word_c;
        rd_valid <= s1_valid;
        if (s1_valid) rd_data <= s1_data;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_fire_c;
        if (rd_fire_c) rd_data <= rd_word_c;
      end
    end
  end

endmodule
